// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg: shared fetch constants and ctrl stall encodings
package if_fetch_queue_pkg;
    localparam int IMEM_DATA_WIDTH = 32;
    localparam logic [IMEM_DATA_WIDTH-1:0] DEFAULT_NOP = 32'h00000013;
    localparam logic STOP = 1'b1;
    localparam logic GO = 1'b0;
endpackage

// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: instruction-memory port
//   req/addr : request from the fetch unit, gnt: request accepted this cycle
//   rvalid/rdata : responses, in request order, at least one cycle after gnt
interface if_fetch_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic req;
    logic [ADDR_WIDTH-1:0] addr;
    logic gnt;
    logic rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_queue_fetch_fifo.sv
// if_fetch_queue_fetch_fifo: in-order storage of in-flight and fetched instructions
//   alloc/alloc_pc : reserve tail entry (unfilled), fill/fill_inst : complete oldest unfilled
//   pop : retire head, clear : drop every entry; count/unfilled/head_* report state
module if_fetch_queue_fetch_fifo #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int DEPTH = 2,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear,
    input  logic          alloc,
    input  logic [AW-1:0] alloc_pc,
    input  logic          fill,
    input  logic [DW-1:0] fill_inst,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [CW-1:0] unfilled,
    output logic [AW-1:0] head_pc,
    output logic [DW-1:0] head_inst,
    output logic          head_filled
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] pc_q [DEPTH];
    logic [DW-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0] wr_ptr, fill_ptr, rd_ptr;

    assign head_pc = pc_q[rd_ptr];
    assign head_inst = inst_q[rd_ptr];
    // stale flags survive pops, so an empty queue never reports a filled head
    assign head_filled = (count != '0) & filled_q[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (alloc) pc_q[wr_ptr] <= alloc_pc;
        if (fill) inst_q[fill_ptr] <= fill_inst;
    end

    // fill only targets an unfilled entry, so it never aliases the alloc slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filled_q <= '0;
            wr_ptr <= '0;
            fill_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            unfilled <= '0;
        end else if (clear) begin
            filled_q <= '0;
            wr_ptr <= '0;
            fill_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            unfilled <= '0;
        end else begin
            if (alloc) begin
                wr_ptr <= wr_ptr + PW'(1);
                filled_q[wr_ptr] <= 1'b0;
            end
            if (fill) begin
                fill_ptr <= fill_ptr + PW'(1);
                filled_q[fill_ptr] <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(alloc) - CW'(pop);
            unfilled <= unfilled + CW'(alloc) - CW'(fill);
        end
    end
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: IF fetch unit between pc_reg and ID
//   pc_i/ce_i : PC and enable from pc_reg, stall_i/flush_i : ctrl pipeline control
//   imem : request/grant + in-order response port, fetch_stall_o : PC not issuable
//   id_pc_o/id_inst_o/id_valid_o : registered instruction handed to ID
module if_fetch_queue import if_fetch_queue_pkg::*; #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH = 2,
    parameter logic [IMEM_DATA_WIDTH-1:0] NOP_INST = DEFAULT_NOP
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [ADDR_WIDTH-1:0]      pc_i,
    input  logic                       ce_i,
    input  logic [5:0]                 stall_i,
    input  logic                       flush_i,
    if_fetch_queue_if.master           imem,
    output logic                       fetch_stall_o,
    output logic [ADDR_WIDTH-1:0]      id_pc_o,
    output logic [IMEM_DATA_WIDTH-1:0] id_inst_o,
    output logic                       id_valid_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0] count, unfilled, drop_cnt, drop_nxt;
    logic issued_q, credit_ok, alloc, fill, pop, head_filled, bubble, unused_ok;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [IMEM_DATA_WIDTH-1:0] head_inst;

    assign unused_ok = &{1'b0, stall_i[5:3]};
    // responses still owed for flushed requests keep consuming queue credit
    assign credit_ok = ({1'b0, count} + {1'b0, drop_cnt}) < (CW+1)'(DEPTH);
    assign imem.req = ce_i & credit_ok & ~issued_q & ~flush_i;
    assign imem.addr = pc_i;
    assign fetch_stall_o = ce_i & ~issued_q & ~(credit_ok & imem.gnt & ~flush_i);
    assign alloc = imem.req & imem.gnt;
    assign fill = imem.rvalid & (drop_cnt == '0) & (unfilled != '0);
    assign pop = ~flush_i & (stall_i[1] == GO) & head_filled;
    assign bubble = flush_i | (stall_i[1] == STOP ? stall_i[2] == GO : ~head_filled);
    // on flush every unfilled entry becomes owed; a same-cycle response settles one of them
    assign drop_nxt = flush_i ? drop_cnt + unfilled - CW'(imem.rvalid & ((drop_cnt != '0) | (unfilled != '0)))
                              : drop_cnt - CW'(imem.rvalid & (drop_cnt != '0));

    if_fetch_queue_fetch_fifo #(
        .AW(ADDR_WIDTH), .DW(IMEM_DATA_WIDTH), .DEPTH(DEPTH), .CW(CW)
    ) u_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear(flush_i),
        .alloc(alloc), .alloc_pc(pc_i), .fill(fill), .fill_inst(imem.rdata), .pop(pop),
        .count(count), .unfilled(unfilled), .head_pc(head_pc), .head_inst(head_inst),
        .head_filled(head_filled)
    );

    // issued_q remembers that the PC held by pc_reg has already been requested
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
            issued_q <= 1'b0;
            id_valid_o <= 1'b0;
            id_pc_o <= '0;
            id_inst_o <= NOP_INST;
        end else begin
            drop_cnt <= drop_nxt;
            issued_q <= (flush_i | (stall_i[0] == GO)) ? 1'b0 : (alloc | issued_q);
            if (bubble) begin
                id_valid_o <= 1'b0;
                id_inst_o <= NOP_INST;
            end else if (stall_i[1] == GO) begin
                id_valid_o <= 1'b1;
                id_pc_o <= head_pc;
                id_inst_o <= head_inst;
            end
        end
    end

    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem.rvalid |-> ((drop_cnt != '0) || (unfilled != '0)));
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ({1'b0, count} + {1'b0, drop_cnt}) <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: randomized self-checking bench with a queue-level reference model
module tb_if_fetch_queue;
    localparam int AW = 32;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {logic [AW-1:0] pc; bit filled;} ent_t;
    typedef struct {logic [AW-1:0] pc; int ready; bit live;} mreq_t;

    logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, flush = 1'b0;
    logic ctrl_st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    logic [AW-1:0] pc = '0;
    logic fetch_stall, id_valid;
    logic [AW-1:0] id_pc;
    logic [31:0] id_inst;
    logic [5:0] stall_vec;

    if_fetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) imem ();

    assign stall_vec = {3'b000, st2, st1, ctrl_st0 | fetch_stall};

    if_fetch_queue #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .ce_i(ce), .stall_i(stall_vec), .flush_i(flush),
        .imem(imem), .fetch_stall_o(fetch_stall), .id_pc_o(id_pc), .id_inst_o(id_inst),
        .id_valid_o(id_valid)
    );

    always #5 clk = ~clk;

    ent_t mq[$];
    mreq_t memq[$];
    logic [AW-1:0] deliv_q[$];
    int cyc = 0, lat_min = 1, lat_max = 1, gnt_pct = 100;
    int checks = 0, passes = 0, hs_cnt = 0;
    bit issued_cur;
    logic [AW-1:0] next_issue, target, last_hs_addr;
    logic exp_valid;
    logic [AW-1:0] exp_pc;
    logic [31:0] exp_inst;
    logic s_req, s_fs;
    logic [AW-1:0] s_addr;

    function automatic logic [31:0] inst_of(logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
    endfunction

    task automatic step();
        bit hs, rv, fl, st0v, want_req, want_fs;
        int occ;
        mreq_t m;
        logic [AW-1:0] a;
        imem.gnt = ($urandom_range(99) < gnt_pct);
        imem.rvalid = (memq.size() > 0) && (memq[0].ready <= cyc);
        imem.rdata = imem.rvalid ? inst_of(memq[0].pc) : $urandom;
        @(negedge clk);
        occ = mq.size();
        foreach (memq[i]) if (!memq[i].live) occ++;
        fl = flush; rv = imem.rvalid; st0v = stall_vec[0]; a = imem.addr;
        s_req = imem.req; s_fs = fetch_stall; s_addr = a;
        hs = imem.req && imem.gnt;
        want_req = ce && !fl && !issued_cur && occ < DEPTH;
        want_fs = ce && !issued_cur && !(occ < DEPTH && imem.gnt && !fl);
        checks++; if (imem.req !== want_req) $display("FAIL req cyc%0d: got %b want %b", cyc, imem.req, want_req); else passes++;
        checks++; if (fetch_stall !== want_fs) $display("FAIL fetch_stall cyc%0d: got %b want %b", cyc, fetch_stall, want_fs); else passes++;
        if (imem.req) begin
            checks++; if (a !== pc) $display("FAIL req_addr cyc%0d: got %h want %h", cyc, a, pc); else passes++;
        end
        if (hs) begin
            checks++; if (a !== next_issue) $display("FAIL issue_order cyc%0d: got %h want %h", cyc, a, next_issue); else passes++;
        end
        if (fl || (st1 && !st2)) begin
            exp_valid = 1'b0; exp_inst = NOP;
        end else if (!st1) begin
            if (mq.size() > 0 && mq[0].filled) begin
                exp_valid = 1'b1; exp_pc = mq[0].pc; exp_inst = inst_of(mq[0].pc);
                deliv_q.push_back(mq[0].pc);
                void'(mq.pop_front());
            end else begin
                exp_valid = 1'b0; exp_inst = NOP;
            end
        end
        @(posedge clk);
        #1;
        if (rv) begin
            m = memq.pop_front();
            if (m.live) for (int i = 0; i < mq.size(); i++) if (!mq[i].filled) begin mq[i].filled = 1'b1; break; end
        end
        if (hs) begin
            mq.push_back('{a, 1'b0});
            memq.push_back('{a, cyc + $urandom_range(lat_max, lat_min), 1'b1});
            next_issue = a + 4; last_hs_addr = a; hs_cnt++;
        end
        if (fl) begin
            mq.delete();
            foreach (memq[i]) memq[i].live = 1'b0;
            next_issue = target;
        end
        issued_cur = (fl || !st0v) ? 1'b0 : (hs || issued_cur);
        if (fl) pc = target; else if (!st0v) pc = pc + 4;
        cyc++;
        checks++; if (id_valid !== exp_valid) $display("FAIL id_valid cyc%0d: got %b want %b", cyc, id_valid, exp_valid); else passes++;
        checks++; if (id_inst !== exp_inst) $display("FAIL id_inst cyc%0d: got %h want %h", cyc, id_inst, exp_inst); else passes++;
        if (exp_valid) begin
            checks++; if (id_pc !== exp_pc) $display("FAIL id_pc cyc%0d: got %h want %h", cyc, id_pc, exp_pc); else passes++;
        end
    endtask

    task automatic drain();
        gnt_pct = 0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        rst_n = 1'b0; ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (id_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", id_valid); else passes++;
        checks++; if (id_pc !== '0) $display("FAIL reset_pc: got %h want 0", id_pc); else passes++;
        checks++; if (id_inst !== NOP) $display("FAIL reset_inst: got %h want %h", id_inst, NOP); else passes++;
        checks++; if (imem.req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem.req); else passes++;
        rst_n = 1'b1; ce = 1'b1;
        issued_cur = 1'b0; next_issue = '0; exp_valid = 1'b0; exp_pc = '0; exp_inst = NOP;
    endtask

    task automatic test_stream();
        int d0;
        d0 = deliv_q.size();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        repeat (20) step();
        checks++; if (deliv_q.size() - d0 < 8) $display("FAIL stream_count: got %0d want >=8", deliv_q.size() - d0); else passes++;
        checks++; if (deliv_q[d0] !== 32'h0) $display("FAIL stream_first_pc: got %h want 0", deliv_q[d0]); else passes++;
    endtask

    task automatic test_gnt_hold();
        logic [AW-1:0] held;
        int h0;
        drain();
        held = pc;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (s_fs !== 1'b1) $display("FAIL gnt_hold_stall: got %b want 1", s_fs); else passes++;
            checks++; if (s_req !== 1'b1 || s_addr !== held) $display("FAIL gnt_hold_req: got %b/%h want 1/%h", s_req, s_addr, held); else passes++;
        end
        gnt_pct = 100; h0 = hs_cnt;
        step();
        checks++; if (hs_cnt != h0 + 1 || last_hs_addr !== held) $display("FAIL gnt_hold_issue: got %0d/%h want 1/%h", hs_cnt - h0, last_hs_addr, held); else passes++;
        repeat (6) step();
    endtask

    task automatic test_stall_hold();
        gnt_pct = 100; st1 = 1'b1; st2 = 1'b1;
        repeat (4) step();
        checks++; if (s_fs !== 1'b1) $display("FAIL stall_hold_full: got %b want 1", s_fs); else passes++;
        st1 = 1'b0; st2 = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_pc_stall();
        int h0;
        drain();
        ctrl_st0 = 1'b1; gnt_pct = 100; h0 = hs_cnt;
        step();
        checks++; if (s_req !== 1'b1) $display("FAIL pc_stall_first_req: got %b want 1", s_req); else passes++;
        repeat (3) begin
            step();
            checks++; if (s_req !== 1'b0) $display("FAIL pc_stall_req_held: got %b want 0", s_req); else passes++;
        end
        checks++; if (hs_cnt != h0 + 1) $display("FAIL pc_stall_issues: got %0d want 1", hs_cnt - h0); else passes++;
        ctrl_st0 = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_flush();
        int h0, d0;
        drain();
        lat_min = 4; lat_max = 4; gnt_pct = 100; h0 = hs_cnt;
        repeat (2) step();
        checks++; if (hs_cnt != h0 + 2) $display("FAIL flush_setup_issues: got %0d want 2", hs_cnt - h0); else passes++;
        gnt_pct = 0; target = 32'h100; flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_inst !== NOP) $display("FAIL flush_bubble: got %b/%h want 0/%h", id_valid, id_inst, NOP); else passes++;
        gnt_pct = 100; lat_min = 1; lat_max = 1; d0 = deliv_q.size();
        repeat (14) step();
        checks++; if (deliv_q.size() <= d0) $display("FAIL flush_resume: got %0d deliveries want >0", deliv_q.size() - d0);
        else if (deliv_q[d0] !== 32'h100) $display("FAIL flush_resume: got %h want 100", deliv_q[d0]); else passes++;
    endtask

    task automatic test_bubble();
        logic [AW-1:0] hp;
        int n;
        gnt_pct = 100; n = 0;
        while (!(mq.size() > 0 && mq[0].filled) && n < 10) begin step(); n++; end
        checks++;
        if (n >= 10) $display("FAIL bubble_setup: got timeout want filled head");
        else begin
            passes++;
            hp = mq[0].pc; st1 = 1'b1; st2 = 1'b0;
            step();
            checks++; if (id_valid !== 1'b0 || id_inst !== NOP) $display("FAIL bubble_out: got %b/%h want 0/%h", id_valid, id_inst, NOP); else passes++;
            st1 = 1'b0;
            step();
            checks++; if (id_valid !== 1'b1 || id_pc !== hp) $display("FAIL bubble_no_pop: got %b/%h want 1/%h", id_valid, id_pc, hp); else passes++;
        end
        repeat (4) step();
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 3; gnt_pct = 70;
        repeat (400) begin
            ctrl_st0 = ($urandom_range(9) == 0);
            st1 = ($urandom_range(4) == 0);
            st2 = ($urandom_range(1) == 0);
            flush = ($urandom_range(19) == 0);
            target = AW'($urandom_range(1023)) << 2;
            step();
        end
        ctrl_st0 = 1'b0; st1 = 1'b0; st2 = 1'b0; flush = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gnt_hold();
        test_stall_hold();
        test_pc_stall();
        test_flush();
        test_bubble();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
